clk_div_multi: RTL and testbench

Parametrised multi-channel clock/tick divider, successor to the single fixed 1 Hz divider. It derives N_CH independent low-rate outputs from CLK_100MHZ. Each channel has a runtime-loadable divisor and mode (square or single-cycle pulse), an enable, and a one-cycle TICK strobe. Divisor/mode changes are applied glitch-free at the channel's terminal count. Typical consumers are display scan, seconds counters and debounce samplers.

---
 rtl/clk_div_multi.sv | 117 +++++++++++
 tb/tb_clk_div_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent clock/tick dividers running from CLK_100MHZ.
// Each channel has a runtime-loadable divisor and mode (square or single-cycle
// pulse). New values wait in a shadow register and take effect only at the
// channel's terminal count, when it is disabled, or on SYNC. That way a
// running output never sees a truncated or stretched interval.
module clk_div_multi #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int N_CH        = 4,
    parameter int DIV_W       = 27,
    parameter int DEFAULT_DIV = CLK_HZ / 2 - 1,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             CLK_100MHZ,
    input  logic             RST,
    input  logic [N_CH-1:0]  EN,
    input  logic             SYNC,
    input  logic             LOAD,
    input  logic [CH_W-1:0]  LOAD_CH,
    input  logic [DIV_W-1:0] DIV_IN,
    input  logic             MODE_IN,
    output logic [N_CH-1:0]  CLK_OUT,
    output logic [N_CH-1:0]  TICK,
    output logic [N_CH-1:0]  PEND
);

    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    // Mode encoding of the MODE_IN / per-channel mode bit.
    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_PULSE  = 1'b1
    } mode_e;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] shadow_div;
        mode_e            mode;
        mode_e            shadow_mode;
        logic             pend;
        logic             out;
        logic             tick;
        logic             terminal;
        logic             apply;
        logic             load_hit;

        // Decode terminal count, shadow apply and load target from pre-edge state.
        // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
        always_comb begin
            terminal = EN[i] && (cnt == div);
            apply    = pend && (SYNC || !EN[i] || terminal);
            // An out-of-range LOAD_CH matches no channel and is dropped.
            load_hit = LOAD && (LOAD_CH == CH_W'(i));
        end

        // Counter, output shaping, shadow apply and shadow write for this channel.
        // NOTE: sequential state uses non-blocking assignments only, so every
        // decision below sees the register values from before the edge.
        always_ff @(posedge CLK_100MHZ or posedge RST) begin
            if (RST) begin
                cnt         <= '0;
                div         <= RESET_DIV;
                mode        <= MODE_SQUARE;
                shadow_div  <= RESET_DIV;
                shadow_mode <= MODE_SQUARE;
                pend        <= 1'b0;
                out         <= 1'b0;
                tick        <= 1'b0;
            end else begin
                if (SYNC || !EN[i]) begin
                    cnt  <= '0;
                    out  <= 1'b0;
                    tick <= 1'b0;
                end else if (terminal) begin
                    // The transition at a terminal uses the mode in force
                    // before any apply on this same edge.
                    cnt <= '0;
                    if (mode == MODE_PULSE) begin
                        out  <= 1'b1;
                        tick <= 1'b1;
                    end else begin
                        out  <= ~out;
                        tick <= ~out;
                    end
                end else begin
                    cnt  <= cnt + DIV_W'(1);
                    tick <= 1'b0;
                    if (mode == MODE_PULSE) begin
                        out <= 1'b0;
                    end
                end

                // Every apply case above also clears cnt, so the new divisor
                // always governs a full interval.
                if (apply) begin
                    div  <= shadow_div;
                    mode <= shadow_mode;
                end

                // A load on the apply edge refills the shadow and stays
                // pending for the following terminal.
                if (load_hit) begin
                    shadow_div  <= DIV_IN;
                    shadow_mode <= mode_e'(MODE_IN);
                    pend        <= 1'b1;
                end else if (apply) begin
                    pend <= 1'b0;
                end
            end
        end

        assign CLK_OUT[i] = out;
        assign TICK[i]    = tick;
        assign PEND[i]    = pend;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi. The main instance has two channels with an
// 8-bit counter and a reset divisor of 3. A second three-channel instance
// exercises an out-of-range LOAD_CH, which a 1-bit select cannot express.
// Edge numbers in the comments count posedges after the reset release.
module tb_clk_div_multi;

    logic       CLK_100MHZ = 1'b0;
    logic       RST        = 1'b1;
    logic [1:0] EN         = 2'b00;
    logic       SYNC       = 1'b0;
    logic       LOAD       = 1'b0;
    logic [0:0] LOAD_CH    = 1'b0;
    logic [7:0] DIV_IN     = 8'd0;
    logic       MODE_IN    = 1'b0;
    logic [1:0] CLK_OUT;
    logic [1:0] TICK;
    logic [1:0] PEND;

    logic [2:0] en3      = 3'b000;
    logic       load3    = 1'b0;
    logic [1:0] load_ch3 = 2'd0;
    logic [2:0] clk_out3;
    logic [2:0] tick3;
    logic [2:0] pend3;

    int checks = 0;
    int errors = 0;

    always #5 CLK_100MHZ = ~CLK_100MHZ;

    clk_div_multi #(
        .CLK_HZ      (100_000_000),
        .N_CH        (2),
        .DIV_W       (8),
        .DEFAULT_DIV (3)
    ) u_dut (
        .CLK_100MHZ (CLK_100MHZ),
        .RST        (RST),
        .EN         (EN),
        .SYNC       (SYNC),
        .LOAD       (LOAD),
        .LOAD_CH    (LOAD_CH),
        .DIV_IN     (DIV_IN),
        .MODE_IN    (MODE_IN),
        .CLK_OUT    (CLK_OUT),
        .TICK       (TICK),
        .PEND       (PEND)
    );

    clk_div_multi #(
        .CLK_HZ      (100_000_000),
        .N_CH        (3),
        .DIV_W       (8),
        .DEFAULT_DIV (3)
    ) u_dut3 (
        .CLK_100MHZ (CLK_100MHZ),
        .RST        (RST),
        .EN         (en3),
        .SYNC       (SYNC),
        .LOAD       (load3),
        .LOAD_CH    (load_ch3),
        .DIV_IN     (DIV_IN),
        .MODE_IN    (MODE_IN),
        .CLK_OUT    (clk_out3),
        .TICK       (tick3),
        .PEND       (pend3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] exp_clk, input logic [1:0] exp_tick);
        check({tag, "_clk"},  32'(CLK_OUT), 32'(exp_clk));
        check({tag, "_tick"}, 32'(TICK),    32'(exp_tick));
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge CLK_100MHZ);
        #1;
    endtask

    task automatic drive_load(input logic ch, input logic [7:0] d, input logic m);
        LOAD    = 1'b1;
        LOAD_CH = ch;
        DIV_IN  = d;
        MODE_IN = m;
    endtask

    initial begin
        // Reset state.
        cyc(2);
        check_out("reset", 2'b00, 2'b00);
        check("reset_pend", 32'(PEND), 32'd0);

        // Release reset with both channels enabled, d=3 square: rise at edge 4, period 8.
        RST = 1'b0;
        EN  = 2'b11;
        cyc(3);  check_out("e03", 2'b00, 2'b00);
        cyc(1);  check_out("e04_rise", 2'b11, 2'b11);
        cyc(1);  check_out("e05", 2'b11, 2'b00);
        cyc(3);  check_out("e08_fall", 2'b00, 2'b00);
        cyc(4);  check_out("e12_rise", 2'b11, 2'b11);

        // Mid-interval load of ch1: d=1 pulse. Applies at ch1's terminal, edge 16.
        cyc(1);  drive_load(1'b1, 8'd1, 1'b1);
        cyc(1);  LOAD = 1'b0;
        check("e14_pend", 32'(PEND), 32'b10);
        cyc(1);  check("e15_pend", 32'(PEND), 32'b10);
        cyc(1);  check("e16_pend", 32'(PEND), 32'b00);
        check_out("e16_apply", 2'b00, 2'b00);
        cyc(1);  check_out("e17", 2'b00, 2'b00);
        cyc(1);  check_out("e18_pulse", 2'b10, 2'b10);
        cyc(1);  check_out("e19", 2'b00, 2'b00);
        cyc(1);  check_out("e20", 2'b11, 2'b11);
        cyc(1);  check_out("e21", 2'b01, 2'b00);

        // Load of ch0 (d=1 square) sampled on ch0's terminal edge 24: old d once more.
        cyc(2);  drive_load(1'b0, 8'd1, 1'b0);
        cyc(1);  LOAD = 1'b0;
        check("e24_pend", 32'(PEND), 32'b01);
        check_out("e24", 2'b10, 2'b10);
        cyc(3);  check("e27_pend", 32'(PEND), 32'b01);
        check_out("e27", 2'b00, 2'b00);
        cyc(1);  check("e28_pend", 32'(PEND), 32'b00);
        check_out("e28_apply", 2'b11, 2'b11);
        cyc(1);  check_out("e29", 2'b01, 2'b00);
        cyc(1);  check_out("e30", 2'b10, 2'b10);
        cyc(2);  check_out("e32", 2'b11, 2'b11);

        // Switch ch1 to d=1 square; the channels end up in opposite phase.
        drive_load(1'b1, 8'd1, 1'b0);
        cyc(1);  LOAD = 1'b0;
        check("e33_pend", 32'(PEND), 32'b10);
        check_out("e33", 2'b01, 2'b00);
        cyc(1);  check_out("e34_old_mode", 2'b10, 2'b10);
        check("e34_pend", 32'(PEND), 32'b00);
        cyc(1);  check_out("e35", 2'b10, 2'b00);
        cyc(1);  check_out("e36_antiphase", 2'b01, 2'b01);

        // SYNC at edge 38 brings both channels into phase.
        cyc(1);  SYNC = 1'b1;
        cyc(1);  SYNC = 1'b0;
        check_out("e38_sync", 2'b00, 2'b00);
        cyc(1);  check_out("e39", 2'b00, 2'b00);
        cyc(1);  check_out("e40_inphase", 2'b11, 2'b11);
        cyc(1);  check_out("e41", 2'b11, 2'b00);
        cyc(1);  check_out("e42", 2'b00, 2'b00);

        // Pending load of ch0 (d=2) applied on the edge after EN[0] drops.
        cyc(1);  drive_load(1'b0, 8'd2, 1'b0);
        cyc(1);  LOAD = 1'b0;
        EN = 2'b10;
        check("e44_pend", 32'(PEND), 32'b01);
        check_out("e44", 2'b11, 2'b11);
        cyc(1);  check("e45_pend", 32'(PEND), 32'b00);
        check_out("e45_dis", 2'b10, 2'b00);
        cyc(2);  check_out("e47_dis", 2'b00, 2'b00);
        EN = 2'b11;
        cyc(2);  check_out("e49", 2'b10, 2'b00);
        cyc(1);  check_out("e50_first", 2'b01, 2'b01);
        cyc(3);  check_out("e53", 2'b10, 2'b00);
        cyc(3);  check_out("e56", 2'b11, 2'b11);

        // Leave a load pending, then assert RST between edges.
        drive_load(1'b1, 8'd5, 1'b0);
        cyc(1);  LOAD = 1'b0;
        check("e57_pend", 32'(PEND), 32'b10);
        check_out("e57", 2'b11, 2'b00);
        #2;
        RST = 1'b1;
        #1;
        check_out("async_rst", 2'b00, 2'b00);
        check("async_rst_pend", 32'(PEND), 32'd0);

        // After release both channels run at d=3 again: rise on the 4th edge.
        cyc(1);
        RST = 1'b0;
        cyc(3);  check_out("rr03", 2'b00, 2'b00);
        cyc(1);  check_out("rr04_rise", 2'b11, 2'b11);
        cyc(4);  check_out("rr08_fall", 2'b00, 2'b00);

        // Three-channel instance: LOAD_CH=3 is ignored, LOAD_CH=2 is taken.
        load3    = 1'b1;
        load_ch3 = 2'd3;
        DIV_IN   = 8'd7;
        MODE_IN  = 1'b1;
        cyc(1);  load3 = 1'b0;
        check("ch3_bad_pend", 32'(pend3), 32'b000);
        load3    = 1'b1;
        load_ch3 = 2'd2;
        cyc(1);  load3 = 1'b0;
        check("ch2_good_pend", 32'(pend3), 32'b100);
        cyc(1);  check("ch2_applied", 32'(pend3), 32'b000);
        check("ch3_clk", 32'(clk_out3), 32'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
